// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder/subtractor: FSM state encoding
// and chunk-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for N/K chunks; at least one bit so K==N still has a counter.
  function automatic int cnt_width(input int n, input int k);
    int w;
    w = $clog2(n / k);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multicycle_adder_sub_if.sv
// Operand/result handshake bundle for multicycle_adder_sub.
interface multicycle_adder_sub_if #(
  parameter int N = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, A, B, sub, cin, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, sub, cin, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );

endinterface

// File: rtl/multicycle_adder_sub_chunk_adder.sv
// K-bit combinational ripple adder built from full-adder stages; the carry
// chain depth of the whole design is bounded by K.
module chunk_adder #(
  parameter int K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         ci,
  output logic [K-1:0] s,
  output logic         co
);

  logic [K:0] carry_s;

  assign carry_s[0] = ci;

  for (genvar i = 0; i < K; i++) begin : g_fa
    assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign co = carry_s[K];

endmodule

// File: rtl/multicycle_adder_sub.sv
// N-bit adder/subtractor computing K bits per cycle with valid/ready handshake.
// Optional saturation on signed overflow when ADDER_SAT_EN is defined.
module multicycle_adder_sub
  import adder_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 8
) (
  input logic                clk,
  input logic                reset_n,
  multicycle_adder_sub_if.slave bus
);

  localparam int             W      = cnt_width(N, K);
  localparam int             CHUNKS = N / K;
  localparam logic [W-1:0]   LAST   = W'(CHUNKS - 1);

  state_t       state_r;
  state_t       state_s;
  logic [W-1:0] cnt_r;
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic [N-1:0] sum_r;
  logic [N-1:0] s_r;
  logic         carry_r;
  logic         cout_r;
  logic         ovf_r;
  logic         in_ready_r;
  logic         out_valid_r;

  logic [K-1:0] a_chunk_s;
  logic [K-1:0] b_chunk_s;
  logic [K-1:0] sum_chunk_s;
  logic         chunk_co_s;
  logic [N-1:0] raw_s;
  logic [N-1:0] final_s;
  logic         ovf_s;
  logic         accept_s;

  assign a_chunk_s = a_r[cnt_r*K +: K];
  assign b_chunk_s = b_r[cnt_r*K +: K];
  assign accept_s  = bus.in_valid && in_ready_r && (state_r == IDLE);

  chunk_adder #(.K(K)) u_chunk (
    .a  (a_chunk_s),
    .b  (b_chunk_s),
    .ci (carry_r),
    .s  (sum_chunk_s),
    .co (chunk_co_s)
  );

  // Full raw sum with the current chunk merged in; complete on the last chunk.
  always_comb begin
    raw_s                 = sum_r;
    raw_s[cnt_r*K +: K]   = sum_chunk_s;
    ovf_s                 = (a_r[N-1] == b_r[N-1]) && (raw_s[N-1] != a_r[N-1]);
  end

  // Result selection: wrap by default, clamp to the signed limit on overflow when enabled.
  always_comb begin
`ifdef ADDER_SAT_EN
    if (ovf_s) begin
      final_s = a_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      final_s = raw_s;
    end
`else
    final_s = raw_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_s = DONE;
        else               state_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Operand capture, chunk accumulation and registered handshake/result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      s_r         <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= bus.A;
            b_r     <= bus.sub ? ~bus.B : bus.B;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          sum_r   <= raw_s;
          carry_r <= chunk_co_s;
          cnt_r   <= cnt_r + W'(1);
          if (cnt_r == LAST) begin
            s_r    <= final_s;
            cout_r <= chunk_co_s;
            ovf_r  <= ovf_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.S         = s_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_multicycle_adder_sub.sv
// Self-checking bench for multicycle_adder_sub (K=8 main instance, K=32 single-cycle instance).
// Honours ADDER_SAT_EN in its expectations.
module tb_multicycle_adder_sub;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_adder_sub_if #(.N(32)) bus ();
  multicycle_adder_sub_if #(.N(32)) bus32 ();

  multicycle_adder_sub #(.N(32), .K(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  multicycle_adder_sub #(.N(32), .K(32)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    logic [32:0] t;
    logic [31:0] be;
    res_t        r;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    r.s    = t[31:0];
    r.cout = t[32];
    r.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
`ifdef ADDER_SAT_EN
    if (r.ovf) r.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Model compare: every cycle the result is valid it must match the oldest accepted op.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("model_S", bus.S, exp_q[0].s);
        check("model_cout", 32'(bus.cout), 32'(exp_q[0].cout));
        check("model_ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin);
    bit ok;
    ok = 1'b0;
    bus.A = a; bus.B = b; bus.sub = sub; bus.cin = cin; bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    if (ok) exp_q.push_back(model(a, b, sub, cin));
    bus.in_valid = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.sub = 1'($urandom); bus.cin = 1'($urandom);
  endtask

  task automatic wait_result(output res_t got, output int lat);
    lat = 0;
    got = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        got = {bus.S, bus.cout, bus.ovf};
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input logic [31:0] s_req,
                        input logic cout_req, input logic ovf_req);
    res_t got;
    int   lat;
    accept_op(a, b, sub, cin);
    wait_result(got, lat);
    check({name, "_latency"}, lat, 32'd4);
    check({name, "_S"}, got.s, s_req);
    check({name, "_cout"}, 32'(got.cout), 32'(cout_req));
    check({name, "_ovf"}, 32'(got.ovf), 32'(ovf_req));
    @(posedge clk); #1;
    check({name, "_idle_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t got;
    int   lat;
    int   seen;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.sub = 1'b0; bus32.cin = 1'b0;
    bus32.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_S", bus.S, 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("wrap_add", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`ifdef ADDER_SAT_EN
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("neg_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`else
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("neg_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    run_op("cin_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0001, 1'b0, 1'b0);

    // Back-pressure in DONE with a stray in_valid pulse.
    bus.out_ready = 1'b0;
    accept_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
    wait_result(got, lat);
    check("hold_latency", lat, 32'd4);
    check("hold_S", got.s, 32'h2143_6587);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 4);
      bus.A = 32'd1; bus.B = 32'd1;
      @(posedge clk); #1;
      check("hold_S_stable", bus.S, got.s);
      check("hold_cout_stable", 32'(bus.cout), 32'(got.cout));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_idle", 32'(bus.out_valid), 32'd0);
    check("hold_release_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("stray_pulse_ignored", seen, 32'd0);

    // Reset two cycles into RUN discards the operation.
    accept_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_S", bus.S, 32'd0);
    check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("no_result_after_rst", seen, 32'd0);
    run_op("after_rst", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);

    // Single-cycle configuration.
    bus32.A = 32'h1234_5678; bus32.B = 32'h1111_1111; bus32.sub = 1'b0; bus32.cin = 1'b0;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    check("k32_in_ready", 32'(bus32.in_ready), 32'd1);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("k32_out_valid", 32'(bus32.out_valid), 32'd1);
    check("k32_S", bus32.S, 32'h2345_6789);
    check("k32_cout", 32'(bus32.cout), 32'd0);
    @(posedge clk); #1;
    check("k32_idle", 32'(bus32.out_valid), 32'd0);
    bus32.A = 32'd5; bus32.B = 32'd7; bus32.sub = 1'b1; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    @(posedge clk); #1;
    check("k32_sub_valid", 32'(bus32.out_valid), 32'd1);
    check("k32_sub_S", bus32.S, 32'hFFFF_FFFE);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
